// File: rtl/seg_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pipe_adder
//  Purpose  : Pipelined segmented ripple-carry adder/subtractor with
//             valid/ready handshakes, carry-out and signed-overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module seg_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NUM_SEG = WIDTH / SEG;

   generate
      if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_param_check
         $error("seg_pipe_adder: WIDTH must be a positive multiple of SEG");
      end
   endgenerate

   // The whole pipeline moves in lock-step; a stalled output freezes every stage.
   logic w_adv;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   genvar k;
   generate
      for (k = 0; k < NUM_SEG; k = k + 1) begin : g_stage
         localparam int SUM_W = (k + 1) * SEG;
         localparam int REM_W = WIDTH - SUM_W;

         logic             w_vin;
         logic [SEG-1:0]   w_sa;
         logic [SEG-1:0]   w_sb;
         logic             w_ci;
         logic [SEG:0]     w_add;
         logic [SUM_W-1:0] w_sum_nxt;
         logic             r_vld;
         logic             r_c;
         logic [SUM_W-1:0] r_s;

         if (k == 0) begin : g_first
            assign w_vin     = in_valid;
            assign w_sa      = a[SEG-1:0];
            assign w_sb      = b[SEG-1:0] ^ {SEG{sub}};
            assign w_ci      = sub | cin;
            assign w_sum_nxt = w_add[SEG-1:0];
         end else begin : g_next
            assign w_vin     = g_stage[k-1].r_vld;
            assign w_sa      = g_stage[k-1].g_ops.r_a[SEG-1:0];
            assign w_sb      = g_stage[k-1].g_ops.r_b[SEG-1:0];
            assign w_ci      = g_stage[k-1].r_c;
            assign w_sum_nxt = {w_add[SEG-1:0], g_stage[k-1].r_s};
         end

         assign w_add = {1'b0, w_sa} + {1'b0, w_sb} + {{SEG{1'b0}}, w_ci};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
               r_c   <= 1'b0;
               r_s   <= '0;
            end else if (w_adv) begin
               r_vld <= w_vin;
               if (w_vin) begin
                  r_c <= w_add[SEG];
                  r_s <= w_sum_nxt;
               end
            end
         end

         // Only operand segments not yet consumed travel further down the pipe.
         if (k < NUM_SEG - 1) begin : g_ops
            logic [REM_W-1:0] r_a;
            logic [REM_W-1:0] r_b;
            logic [REM_W-1:0] w_a_nxt;
            logic [REM_W-1:0] w_b_nxt;

            if (k == 0) begin : g_src_in
               assign w_a_nxt = a[WIDTH-1:SEG];
               assign w_b_nxt = b[WIDTH-1:SEG] ^ {REM_W{sub}};
            end else begin : g_src_prev
               assign w_a_nxt = g_stage[k-1].g_ops.r_a[REM_W+SEG-1:SEG];
               assign w_b_nxt = g_stage[k-1].g_ops.r_b[REM_W+SEG-1:SEG];
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_a <= '0;
                  r_b <= '0;
               end else if (w_adv && w_vin) begin
                  r_a <= w_a_nxt;
                  r_b <= w_b_nxt;
               end
            end
         end else begin : g_last
            logic w_msb_cin;
            logic r_ovf;

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            assign w_msb_cin = w_sa[SEG-1] ^ w_sb[SEG-1] ^ w_add[SEG-1];

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_ovf <= 1'b0;
               end else if (w_adv && w_vin) begin
                  r_ovf <= w_msb_cin ^ w_add[SEG];
               end
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[NUM_SEG-1].r_vld;
   assign sum       = g_stage[NUM_SEG-1].r_s;
   assign cout      = g_stage[NUM_SEG-1].r_c;
   assign ovf       = g_stage[NUM_SEG-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_pipe_adder
//  Purpose  : Directed and randomised checks of seg_pipe_adder (32/8, 12/4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_pipe_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0;
   logic [31:0] a0, b0, sum0;
   logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
   logic [11:0] a1, b1, sum1;

   int n_checks = 0;
   int n_pass   = 0;

   seg_pipe_adder #(.WIDTH(32), .SEG(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid0), .in_ready(in_ready0),
      .a(a0), .b(b0), .cin(cin0), .sub(sub0),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .sum(sum0), .cout(cout0), .ovf(ovf0)
   );

   seg_pipe_adder #(.WIDTH(12), .SEG(4)) u_dut12 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .sub(sub1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat on the 32-bit DUT and waits (bounded) for its result.
   task automatic xfer(input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic c_i, input logic s_i,
                       output logic [31:0] s_o, output logic c_o, output logic o_o,
                       output int lat, output bit ok);
      a0 = a_i; b0 = b_i; cin0 = c_i; sub0 = s_i; in_valid0 = 1'b1; out_ready0 = 1'b1;
      ok = 1'b0; s_o = '0; c_o = 1'b0; o_o = 1'b0;
      step();
      in_valid0 = 1'b0;
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         if (out_valid0) begin
            ok = 1'b1; s_o = sum0; c_o = cout0; o_o = ovf0;
            break;
         end
         step();
         lat++;
      end
   endtask

   function automatic logic [34:0] model(input int w, input logic [31:0] a_i,
                                         input logic [31:0] b_i, input logic c_i,
                                         input logic s_i);
      logic [31:0] mask, aa, be, r;
      logic [32:0] t;
      logic        co, ov, cc;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      aa   = a_i & mask;
      be   = (s_i ? ~b_i : b_i) & mask;
      cc   = s_i ? 1'b1 : c_i;
      t    = {1'b0, aa} + {1'b0, be} + {32'b0, cc};
      r    = t[31:0] & mask;
      co   = t[w];
      ov   = (aa[w-1] == be[w-1]) && (r[w-1] != aa[w-1]);
      return {ov, co, r};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; out_ready0 = 1'b0;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
      repeat (3) step();
      n_checks++;
      if ({out_valid0, sum0, cout0, ovf0} !== 35'd0)
         $display("FAIL reset_outputs: got %h required 0", {out_valid0, sum0, cout0, ovf0});
      else n_pass++;
      n_checks++;
      if (out_valid1 !== 1'b0) $display("FAIL reset_valid12: got %b required 0", out_valid1);
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready0);
      else n_pass++;
   endtask

   task automatic test_latency();
      step();
      a0 = 32'h1; b0 = 32'h2; cin0 = 1'b0; sub0 = 1'b0; in_valid0 = 1'b1; out_ready0 = 1'b1;
      #1;
      n_checks++;
      if (in_ready0 !== 1'b1) $display("FAIL lat_accept: in_ready %b required 1", in_ready0);
      else n_pass++;
      step();
      in_valid0 = 1'b0; a0 = '0; b0 = '0;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         n_checks++;
         if (out_valid0 !== 1'b0 || sum0 !== 32'h0)
            $display("FAIL lat_early cycle %0d: valid %b sum %h required 0/0", cyc, out_valid0, sum0);
         else n_pass++;
         step();
      end
      n_checks++;
      if ({out_valid0, sum0, cout0, ovf0} !== {1'b1, 32'h3, 1'b0, 1'b0})
         $display("FAIL lat_result: valid %b sum %h cout %b ovf %b required 1 00000003 0 0",
                  out_valid0, sum0, cout0, ovf0);
      else n_pass++;
      step();
      n_checks++;
      if (out_valid0 !== 1'b0) $display("FAIL lat_drop: valid %b required 0", out_valid0);
      else n_pass++;
   endtask

   task automatic test_carry_ripple();
      logic [31:0] s; logic c, o; int lat; bit ok;
      step();
      xfer(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, c, o, lat, ok);
      n_checks++;
      if (!ok || lat != 4 || {s, c, o} !== {32'h0, 1'b1, 1'b0})
         $display("FAIL ripple_all_ones: ok %b lat %0d sum %h cout %b ovf %b required 1 4 00000000 1 0",
                  ok, lat, s, c, o);
      else n_pass++;
      xfer(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, lat, ok);
      n_checks++;
      if (!ok || {s, c, o} !== {32'h8000_0000, 1'b0, 1'b1})
         $display("FAIL ripple_ovf: ok %b sum %h cout %b ovf %b required 1 80000000 0 1", ok, s, c, o);
      else n_pass++;
   endtask

   task automatic test_subtract();
      logic [31:0] s; logic c, o; int lat; bit ok;
      xfer(32'd5, 32'd7, 1'b0, 1'b1, s, c, o, lat, ok);
      n_checks++;
      if (!ok || {s, c, o} !== {32'hFFFF_FFFE, 1'b0, 1'b0})
         $display("FAIL sub_borrow: ok %b sum %h cout %b ovf %b required 1 fffffffe 0 0", ok, s, c, o);
      else n_pass++;
      xfer(32'h8000_0000, 32'h1, 1'b0, 1'b1, s, c, o, lat, ok);
      n_checks++;
      if (!ok || {s, c, o} !== {32'h7FFF_FFFF, 1'b1, 1'b1})
         $display("FAIL sub_ovf: ok %b sum %h cout %b ovf %b required 1 7fffffff 1 1", ok, s, c, o);
      else n_pass++;
      xfer(32'd10, 32'd3, 1'b1, 1'b1, s, c, o, lat, ok);
      n_checks++;
      if (!ok || {s, c, o} !== {32'h7, 1'b1, 1'b0})
         $display("FAIL sub_cin_ignored: ok %b sum %h cout %b ovf %b required 1 00000007 1 0", ok, s, c, o);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      logic [31:0] got[$];
      for (int n = 1; n <= 30; n++) begin
         step();
         in_valid0  = (acc < 6);
         a0         = 32'(acc + 1);
         b0         = 32'(acc + 1);
         cin0       = 1'b0;
         sub0       = 1'b0;
         out_ready0 = !(n >= 5 && n <= 8);
         #1;
         if (n >= 5 && n <= 8) begin
            n_checks++;
            if (in_ready0 !== 1'b0) $display("FAIL bp_in_ready cycle %0d: got %b required 0", n, in_ready0);
            else n_pass++;
            n_checks++;
            if (out_valid0 !== 1'b1 || sum0 !== 32'd2)
               $display("FAIL bp_hold cycle %0d: valid %b sum %h required 1 00000002", n, out_valid0, sum0);
            else n_pass++;
         end
         if (in_valid0 && in_ready0) acc++;
         if (out_valid0 && out_ready0) got.push_back(sum0);
      end
      in_valid0 = 1'b0;
      n_checks++;
      if (got.size() != 6) $display("FAIL bp_count: got %0d results required 6", got.size());
      else n_pass++;
      for (int i = 0; i < got.size() && i < 6; i++) begin
         n_checks++;
         if (got[i] !== 32'(2 * (i + 1)))
            $display("FAIL bp_order[%0d]: got %h required %h", i, got[i], 32'(2 * (i + 1)));
         else n_pass++;
      end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] s; logic c, o; int lat; bit ok; bit seen;
      step();
      out_ready0 = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         a0 = 32'(i); b0 = 32'(i); cin0 = 1'b0; sub0 = 1'b0; in_valid0 = 1'b1;
         step();
      end
      in_valid0 = 1'b0;
      step();
      #2;
      n_checks++;
      if (out_valid0 !== 1'b1) $display("FAIL midrst_pre: valid %b required 1", out_valid0);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid0 !== 1'b0 || sum0 !== 32'h0)
         $display("FAIL midrst_async: valid %b sum %h required 0 00000000", out_valid0, sum0);
      else n_pass++;
      #10;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid0) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) $display("FAIL midrst_stale: stale result seen %b required 0", seen);
      else n_pass++;
      xfer(32'd100, 32'd23, 1'b0, 1'b0, s, c, o, lat, ok);
      n_checks++;
      if (!ok || lat != 4 || s !== 32'd123)
         $display("FAIL midrst_recover: ok %b lat %0d sum %h required 1 4 0000007b", ok, lat, s);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [34:0] q0[$];
      logic [34:0] q1[$];
      logic [34:0] e;
      for (int n = 0; n < 420; n++) begin
         step();
         in_valid0  = (n < 400) && ($urandom % 10 < 7);
         out_ready0 = (n >= 400) || ($urandom % 10 < 7);
         a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom); sub0 = 1'($urandom);
         if (n % 17 == 3) a0 = 32'hFFFF_FFFF;
         in_valid1  = (n < 400) && ($urandom % 10 < 6);
         out_ready1 = (n >= 400) || ($urandom % 10 < 6);
         a1 = 12'($urandom); b1 = 12'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
         #1;
         if (in_valid0 && in_ready0) q0.push_back(model(32, a0, b0, cin0, sub0));
         if (in_valid1 && in_ready1) q1.push_back(model(12, {20'h0, a1}, {20'h0, b1}, cin1, sub1));
         if (out_valid0 && out_ready0) begin
            n_checks++;
            if (q0.size() == 0) $display("FAIL rand32_extra: unexpected result %h", sum0);
            else begin
               e = q0.pop_front();
               if ({ovf0, cout0, sum0} !== e)
                  $display("FAIL rand32: got ovf/cout/sum %h required %h", {ovf0, cout0, sum0}, e);
               else n_pass++;
            end
         end
         if (out_valid1 && out_ready1) begin
            n_checks++;
            if (q1.size() == 0) $display("FAIL rand12_extra: unexpected result %h", sum1);
            else begin
               e = q1.pop_front();
               if ({ovf1, cout1, 20'h0, sum1} !== e)
                  $display("FAIL rand12: got ovf/cout/sum %h required %h", {ovf1, cout1, 20'h0, sum1}, e);
               else n_pass++;
            end
         end
      end
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      n_checks++;
      if (q0.size() != 0 || q1.size() != 0)
         $display("FAIL rand_drain: pending %0d/%0d required 0/0", q0.size(), q1.size());
      else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency();
      test_carry_ripple();
      test_subtract();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. Successor to the fixed 8-bit ripple adder.
- The operand is split into SEG-bit segments. Each pipeline stage adds one segment and registers the carry into the next stage, so the critical path is one segment rather than the full width.
- Sits between operand producers and result consumers, with valid/ready handshakes on both sides.
- Adds add/subtract mode, carry-out and signed-overflow flags.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of SEG. Elaboration error otherwise.
- SEG, 8, bits added per pipeline stage. NUM_SEG = WIDTH/SEG = latency in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode only).
- sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out. In sub mode, 1 = no borrow (A>=B unsigned).
- ovf  out  1  signed overflow.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once rst_n deasserts.
- Reset mid-operation discards all in-flight beats. No partial result is ever presented.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages shift only when adv=1; when adv=0 every register holds.
- Accept: on a clock edge with in_valid && in_ready. Stage 0 captures the full operands, an effective B (b XOR {WIDTH{sub}}) and effective carry (sub ? 1 : cin).
- Stage k (0..NUM_SEG-1) adds segment k of A and effective B plus the registered carry from stage k-1 (stage 0 uses the effective carry).
  - It registers the SEG-bit partial sum, the carry, the not-yet-used upper operand segments and the already-computed lower sum segments.
  - Skew: result segments are fully aligned at the output; no de-skew is needed by the consumer.
- Latency: exactly NUM_SEG cycles from an accepted beat to out_valid, with no back-pressure. Throughput is one beat per cycle.
- Bubbles (in_valid=0 while adv=1) propagate as valid=0 stage entries; they are not collapsed.
- Output: sum, cout and ovf are registered and stable while out_valid && !out_ready. out_valid drops the cycle after handshake if no new result follows.
- ovf = carry into MSB XOR carry out of MSB, taken from the final stage (signed two's complement overflow, same rule for add and sub).
- Wrap-around: sum is modulo 2^WIDTH. No saturation.
- Simultaneous out handshake and new input in the same cycle are both legal (full-throughput streaming).
- NUM_SEG=1 degenerates to a single registered adder with latency 1.

Test Plan:
- Reset/latency: WIDTH=32, SEG=8. a=0x0000_0001, b=0x0000_0002, cin=0, sub=0, out_ready=1 → out_valid rises exactly 4 cycles after accept, sum=0x0000_0003, cout=0, ovf=0. Before that, outputs show the reset values.
- Full carry ripple across all segments: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 → sum=0x0000_0000, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1, cin=0 → sum=0x8000_0000, cout=0, ovf=1.
- Subtract: sub=1, a=5, b=7 → sum=0xFFFF_FFFE, cout=0. Then a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, cout=1, ovf=1.
- Back-pressure: stream 6 beats (a=i, b=i, i=1..6), holding out_ready=0 for cycles 5-8 → in_ready=0 during the hold; the first result (sum=2) stays stable. After release, results 2,4,6,8,10,12 appear in order with no loss or duplication.
- Reset mid-flight: accept 3 beats, assert rst_n=0 asynchronously between edges → out_valid=0 immediately. After release, no stale result ever appears.
- Random streaming with random in_valid/out_ready, WIDTH=32/SEG=8 and WIDTH=12/SEG=4 → scoreboard matches (a ± b + cin) mod 2^WIDTH plus cout and ovf for every beat.
